// File: rtl/relop_pkg.sv
// Shared types and helpers for the bit-serial relational comparator.
//   op_e    : relation select encoding carried on the 'op' port.
//   state_e : controller states (IDLE accepts, SCAN walks bits, DONE holds result).
//   relop_c : maps the operator and the lt/gt/eq outcome to the 1-bit result.
package relop_pkg;

  typedef enum logic [1:0] {
    OP_LT = 2'b00,
    OP_GT = 2'b01,
    OP_LE = 2'b10,
    OP_GE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_e;

  // Pure mapping from (op, outcome flags) to the relation result.
  function automatic logic relop_c(op_e op, logic lt, logic gt, logic eq);
    logic res;
    case (op)
      OP_LT:   res = lt;
      OP_GT:   res = gt;
      OP_LE:   res = lt | eq;
      OP_GE:   res = gt | eq;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/relop_serial_cmp.sv
// Bit-serial, MSB-first unsigned magnitude comparator with early termination.
// Ports:
//   clk, rst                 : clock and asynchronous active-high reset
//   in_valid/in_ready, a,b,op: operand handshake; captured only in IDLE
//   out_valid/out_ready      : result handshake; result held while stalled
//   c                        : result of (a op b)
//   lt, gt, eq               : magnitude outcome flags (one-hot when out_valid)
//   busy                     : high while scanning or holding a result
module relop_serial_cmp
  import relop_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             busy
);

  // A 1-bit operand still needs a 1-bit index register.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_e           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  op_e              op_q;
  logic [IDX_W-1:0] idx;

  logic bit_a;
  logic bit_b;

  assign bit_a    = a_q[idx];
  assign bit_b    = b_q[idx];
  assign in_ready = (state == IDLE);
  assign busy     = (state == SCAN) || (state == DONE);

  // Controller, operand capture, bit scan and registered result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_LT;
      idx       <= '0;
      out_valid <= 1'b0;
      c         <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_e'(op);
            idx   <= IDX_MSB;
            state <= SCAN;
          end
        end
        SCAN: begin
          // First differing bit from the MSB decides; equal down to bit 0 means a == b.
          if (bit_a && !bit_b) begin
            gt        <= 1'b1;
            c         <= relop_c(op_q, 1'b0, 1'b1, 1'b0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (!bit_a && bit_b) begin
            lt        <= 1'b1;
            c         <= relop_c(op_q, 1'b1, 1'b0, 1'b0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx == IDX_ZERO) begin
            eq        <= 1'b1;
            c         <= relop_c(op_q, 1'b0, 1'b0, 1'b1);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IDX_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            c         <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          c         <= 1'b0;
          lt        <= 1'b0;
          gt        <= 1'b0;
          eq        <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relop_serial_cmp.sv
// Self-checking bench for relop_serial_cmp (WIDTH = 3): directed cases,
// back-pressure, mid-scan reset, queued back-to-back input and random pairs,
// all checked against an arithmetic reference model.
module tb_relop_serial_cmp;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         c, lt, gt, eq, busy;

  int n_cmp = 0;
  int n_err = 0;

  relop_serial_cmp #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .lt(lt), .gt(gt), .eq(eq), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: edges from accept to result = W - (index of first differing bit).
  function automatic int ref_k(input int xa, input int xb);
    for (int i = W - 1; i >= 0; i--)
      if (((xa >> i) & 1) != ((xb >> i) & 1)) return W - i;
    return W;
  endfunction

  // Reference relation straight from the operator meaning.
  function automatic logic ref_c(input int xop, input int xa, input int xb);
    case (xop)
      0: return xa < xb;
      1: return xa > xb;
      2: return xa <= xb;
      default: return xa >= xb;
    endcase
  endfunction

  // Present one operand pair, wait for acceptance, then count edges until out_valid.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic [1:0] xop, output int lat);
    int g;
    @(negedge clk);
    a = xa; b = xb; op = xop; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  // Complete the output handshake with a one-cycle out_ready pulse.
  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({out_valid, c, lt, gt, eq, busy, in_ready} !== 7'b0000001) begin
      n_err++; $display("FAIL reset_outputs got=%b exp=0000001", {out_valid, c, lt, gt, eq, busy, in_ready}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_err++; $display("FAIL reset_release got=%b exp=001", {out_valid, busy, in_ready}); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{3'b000, 3'b111, 3'b000, 3'b000};
    logic [W-1:0] tb [4] = '{3'b101, 3'b101, 3'b000, 3'b000};
    logic [1:0]   to [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    int ek [4] = '{1, 2, 3, 3};
    logic [3:0] er [4] = '{4'b1100, 4'b0010, 4'b0001, 4'b1001}; // {c,lt,gt,eq}
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], to[i], lat);
      n_cmp++; if (lat !== ek[i]) begin
        n_err++; $display("FAIL directed_lat[%0d] got=%0d exp=%0d", i, lat, ek[i]); end
      n_cmp++; if ({c, lt, gt, eq} !== er[i]) begin
        n_err++; $display("FAIL directed_res[%0d] got=%b exp=%b", i, {c, lt, gt, eq}, er[i]); end
      release_out();
      n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
        n_err++; $display("FAIL directed_release[%0d] got=%b exp=01", i, {out_valid, in_ready}); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(3'b110, 3'b101, 2'b11, lat);
    n_cmp++; if (lat !== 2) begin
      n_err++; $display("FAIL bp_lat got=%0d exp=2", lat); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if ({out_valid, c, lt, gt, eq, in_ready, busy} !== 7'b1101001) begin
        n_err++; $display("FAIL bp_hold[%0d] got=%b exp=1101001", i, {out_valid, c, lt, gt, eq, in_ready, busy}); end
    end
    release_out();
    n_cmp++; if ({out_valid, c, gt, in_ready, busy} !== 5'b00010) begin
      n_err++; $display("FAIL bp_release got=%b exp=00010", {out_valid, c, gt, in_ready, busy}); end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    @(negedge clk);
    a = 3'b011; b = 3'b010; op = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if ({busy, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL mid_scan_busy got=%b exp=10", {busy, out_valid}); end
    rst = 1'b1; #1;
    n_cmp++; if ({out_valid, c, lt, gt, eq, busy, in_ready} !== 7'b0000001) begin
      n_err++; $display("FAIL mid_scan_reset got=%b exp=0000001", {out_valid, c, lt, gt, eq, busy, in_ready}); end
    #2; rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (out_valid || busy) seen++; end
    n_cmp++; if (seen !== 0) begin
      n_err++; $display("FAIL mid_scan_stale got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(3'b001, 3'b001, 2'b11, lat);  // equal pair, GE -> c=1, eq=1
    n_cmp++; if ({lat == 3, c, eq} !== 3'b111) begin
      n_err++; $display("FAIL b2b_first got=%b exp=111", {lat == 3, c, eq}); end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 3'b010; b = 3'b100; op = 2'b11;
    @(posedge clk); #1;  // output handshake; queued input must not be taken yet
    n_cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_err++; $display("FAIL b2b_idle got=%b exp=010", {out_valid, in_ready, busy}); end
    @(posedge clk); #1;  // accepted on first IDLE edge
    in_valid = 1'b0;
    n_cmp++; if ({in_ready, busy} !== 2'b01) begin
      n_err++; $display("FAIL b2b_accept got=%b exp=01", {in_ready, busy}); end
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, c, lt, gt, eq} !== 5'b10100) begin
      n_err++; $display("FAIL b2b_second got=%b exp=10100", {out_valid, c, lt, gt, eq}); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL b2b_done got=%b exp=01", {out_valid, in_ready}); end
  endtask

  task automatic test_random();
    int lat, xa, xb, xo, hold, ek;
    logic ec;
    for (int t = 0; t < 60; t++) begin
      xa = int'($urandom_range(0, 7)); xb = int'($urandom_range(0, 7)); xo = int'($urandom_range(0, 3));
      if (t % 8 == 0) xb = xa;
      send(W'(xa), W'(xb), 2'(xo), lat);
      ek = ref_k(xa, xb);
      ec = ref_c(xo, xa, xb);
      n_cmp++; if (lat !== ek) begin
        n_err++; $display("FAIL rnd_lat a=%0d b=%0d got=%0d exp=%0d", xa, xb, lat, ek); end
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) @(negedge clk);
      n_cmp++; if ({out_valid, c, lt, gt, eq} !== {1'b1, ec, xa < xb, xa > xb, xa == xb}) begin
        n_err++; $display("FAIL rnd_res a=%0d b=%0d op=%0d got=%b exp=%b", xa, xb, xo,
                          {out_valid, c, lt, gt, eq}, {1'b1, ec, xa < xb, xa > xb, xa == xb}); end
      release_out();
      n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
        n_err++; $display("FAIL rnd_release got=%b exp=01", {out_valid, in_ready}); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
